// File: rtl/lc3b_types.sv
// LC-3b shared types: condition-code field and its one-hot encodings.
package lc3b_types;

  typedef logic [2:0] lc3b_nzp;

  localparam lc3b_nzp NZP_N = 3'b100;
  localparam lc3b_nzp NZP_Z = 3'b010;
  localparam lc3b_nzp NZP_P = 3'b001;

endpackage

// File: rtl/nzp_gen.sv
// Combinational NZP generator: classifies a word as negative, zero or positive.
module nzp_gen
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic [2:0]       nzp
);

  always_comb begin
    nzp = NZP_P;
    unique case (1'b1)
      (data == '0):  nzp = NZP_Z;
      data[WIDTH-1]: nzp = NZP_N;
      default:       nzp = NZP_P;
    endcase
  end

endmodule

// File: rtl/nzp_branch_unit.sv
// Multi-context LC-3b CC file with a one-entry registered branch stage.
// Define CC_FORWARD_EN to bypass a same-cycle CC write into the branch.
module nzp_branch_unit
  import lc3b_types::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_CTX = 4,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_cc,
  input  logic [CTX_W-1:0] cc_ctx,
  input  logic [WIDTH-1:0] cc_data,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [CTX_W-1:0] br_ctx,
  input  logic [2:0]       br_nzp,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_taken,
  output logic [CTX_W-1:0] resp_ctx,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CTX_W:0]   CTX_LIM = (CTX_W+1)'(NUM_CTX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lc3b_nzp cc_file [NUM_CTX];
  lc3b_nzp wr_nzp;
  lc3b_nzp rd_nzp;
  lc3b_nzp cc_sel;
  logic    wr_ok;
  logic    rd_ok;
  logic    accept;
  logic    taken_nxt;

  nzp_gen #(.WIDTH(WIDTH)) u_gen (
    .data (cc_data),
    .nzp  (wr_nzp)
  );

  // Out-of-range contexts read as 000 so any branch on them is not taken.
  assign wr_ok  = {1'b0, cc_ctx} < CTX_LIM;
  assign rd_ok  = {1'b0, br_ctx} < CTX_LIM;
  assign rd_nzp = rd_ok ? cc_file[br_ctx] : '0;

`ifdef CC_FORWARD_EN
  assign cc_sel = (ld_cc && wr_ok && (cc_ctx == br_ctx))
                ? wr_nzp : rd_nzp;
`else
  assign cc_sel = rd_nzp;
`endif

  assign br_ready  = !resp_valid || resp_ready;
  assign accept    = br_valid && br_ready;
  assign taken_nxt = |(cc_sel & br_nzp);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        cc_file[i] <= NZP_Z;
      end
    end else if (ld_cc && wr_ok) begin
      cc_file[cc_ctx] <= wr_nzp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_taken <= 1'b0;
      resp_ctx   <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_taken <= taken_nxt;
      resp_ctx   <= br_ctx;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (accept && taken_nxt && (taken_cnt != CNT_MAX)) begin
      taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nzp_branch_unit.sv
// Randomised and directed bench for nzp_branch_unit against a sign-based model.
module tb_nzp_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_cc;
  logic [1:0]  cc_ctx;
  logic [15:0] cc_data;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_ctx;
  logic [2:0]  br_nzp;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [1:0]  resp_ctx;
  logic [1:0]  taken_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model: sign class per context (-1 neg, 0 zero, +1 pos)
  int m_cc [4];
  bit m_valid;
  bit m_taken;
  int m_ctx;
  int m_cnt;

  nzp_branch_unit #(
    .WIDTH(16), .NUM_CTX(4), .CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_cc      (ld_cc),
    .cc_ctx     (cc_ctx),
    .cc_data    (cc_data),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_ctx     (br_ctx),
    .br_nzp     (br_nzp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_taken (resp_taken),
    .resp_ctx   (resp_ctx),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic int kind(input logic [15:0] d);
    if (d == 16'd0) return 0;
    if ($signed(d) < 0) return -1;
    return 1;
  endfunction

  function automatic bit taken_of(input int k, input logic [2:0] n);
    return (k < 0 && n[2]) || (k == 0 && n[1]) || (k > 0 && n[0]);
  endfunction

  task automatic idle();
    rst = 0; ld_cc = 0; cc_ctx = 0; cc_data = 0;
    br_valid = 0; br_ctx = 0; br_nzp = 0; resp_ready = 1;
  endtask

  task automatic tick();
    bit acc, tk, r, ld, rr;
    int sel, wk, wc, bc;
    r   = rst;
    ld  = ld_cc;
    rr  = resp_ready;
    wc  = cc_ctx;
    wk  = kind(cc_data);
    bc  = br_ctx;
    acc = br_valid && (!m_valid || rr);
    sel = m_cc[bc];
`ifdef CC_FORWARD_EN
    if (ld && wc == bc) sel = wk;
`endif
    tk = taken_of(sel, br_nzp);
    @(posedge clk);
    if (r) begin
      foreach (m_cc[i]) m_cc[i] = 0;
      m_valid = 0; m_taken = 0; m_ctx = 0; m_cnt = 0;
    end else begin
      if (ld) m_cc[wc] = wk;
      if (acc) begin
        m_valid = 1; m_taken = tk; m_ctx = bc;
        if (tk && m_cnt < 3) m_cnt++;
      end else if (rr) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
    n_cmp += 4;
    if (resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0", resp_valid);
    end
    if (resp_taken !== 1'b0) begin
      n_bad++; $display("FAIL reset_taken got %b want 0", resp_taken);
    end
    if (resp_ctx !== 2'd0) begin
      n_bad++; $display("FAIL reset_ctx got %0d want 0", resp_ctx);
    end
    if (taken_cnt !== 2'd0) begin
      n_bad++; $display("FAIL reset_cnt got %0d want 0", taken_cnt);
    end
    br_valid = 1; br_ctx = 0; br_nzp = 3'b010;
    tick();
    n_cmp += 2;
    if (resp_valid !== 1'b1) begin
      n_bad++; $display("FAIL z_valid got %b want 1", resp_valid);
    end
    if (resp_taken !== 1'b1) begin
      n_bad++; $display("FAIL z_taken got %b want 1", resp_taken);
    end
    br_nzp = 3'b101;
    tick();
    n_cmp++;
    if (resp_taken !== 1'b0) begin
      n_bad++; $display("FAIL z_nt got %b want 0", resp_taken);
    end
    idle();
    tick();
  endtask

  task automatic test_contexts();
    idle();
    ld_cc = 1; cc_ctx = 2; cc_data = 16'h8000;
    tick();
    ld_cc = 0;
    br_valid = 1; br_ctx = 2; br_nzp = 3'b100;
    tick();
    n_cmp += 2;
    if (resp_taken !== 1'b1) begin
      n_bad++; $display("FAIL ctx2_neg got %b want 1", resp_taken);
    end
    if (resp_ctx !== 2'd2) begin
      n_bad++; $display("FAIL ctx2_id got %0d want 2", resp_ctx);
    end
    br_ctx = 1;
    tick();
    n_cmp += 2;
    if (resp_taken !== 1'b0) begin
      n_bad++; $display("FAIL ctx1_neg got %b want 0", resp_taken);
    end
    if (resp_ctx !== 2'd1) begin
      n_bad++; $display("FAIL ctx1_id got %0d want 1", resp_ctx);
    end
    idle();
    tick();
  endtask

  task automatic test_forward();
    bit exp;
`ifdef CC_FORWARD_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    idle();
    ld_cc = 1; cc_ctx = 0; cc_data = 16'h0005;
    br_valid = 1; br_ctx = 0; br_nzp = 3'b001;
    tick();
    n_cmp++;
    if (resp_taken !== exp) begin
      n_bad++; $display("FAIL fwd got %b want %b", resp_taken, exp);
    end
    ld_cc = 0;
    tick();
    n_cmp++;
    if (resp_taken !== 1'b1) begin
      n_bad++; $display("FAIL fwd_after got %b want 1", resp_taken);
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic       t0;
    logic [1:0] c0;
    idle();
    br_valid = 1; br_ctx = 2; br_nzp = 3'b100; resp_ready = 0;
    tick();
    t0 = resp_taken; c0 = resp_ctx;
    n_cmp += 2;
    if (resp_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_valid got %b want 1", resp_valid);
    end
    if (t0 !== m_taken) begin
      n_bad++; $display("FAIL bp_taken got %b want %b", t0, m_taken);
    end
    for (int i = 0; i < 3; i++) begin
      br_ctx = 2'(i); br_nzp = 3'b010;
      #1;
      n_cmp += 3;
      if (br_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_ready got %b want 0", br_ready);
      end
      tick();
      if (resp_taken !== t0) begin
        n_bad++; $display("FAIL bp_hold_t got %b want %b", resp_taken, t0);
      end
      if (resp_ctx !== c0) begin
        n_bad++; $display("FAIL bp_hold_c got %0d want %0d", resp_ctx, c0);
      end
    end
    resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      br_ctx = 2'(3 - i); br_nzp = 3'(i + 1);
      #1;
      n_cmp += 4;
      if (br_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready got %b want 1", br_ready);
      end
      tick();
      if (resp_valid !== 1'b1) begin
        n_bad++; $display("FAIL b2b_valid got %b want 1", resp_valid);
      end
      if (resp_ctx !== 2'(3 - i)) begin
        n_bad++; $display("FAIL b2b_ctx got %0d want %0d", resp_ctx, 3 - i);
      end
      if (resp_taken !== m_taken) begin
        n_bad++; $display("FAIL b2b_taken got %b want %b", resp_taken, m_taken);
      end
    end
    br_valid = 0;
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain got %b want 0", resp_valid);
    end
  endtask

  task automatic test_saturate();
    idle();
    rst = 1;
    tick();
    rst = 0;
    br_valid = 1; br_ctx = 1; br_nzp = 3'b000;
    repeat (3) tick();
    n_cmp += 2;
    if (taken_cnt !== 2'd0) begin
      n_bad++; $display("FAIL nzp000_cnt got %0d want 0", taken_cnt);
    end
    if (resp_taken !== 1'b0) begin
      n_bad++; $display("FAIL nzp000_t got %b want 0", resp_taken);
    end
    br_nzp = 3'b111;
    for (int k = 1; k <= 5; k++) begin
      br_ctx = 2'(k);
      tick();
      n_cmp += 2;
      if (taken_cnt !== 2'((k > 3) ? 3 : k)) begin
        n_bad++; $display("FAIL sat_cnt got %0d want %0d", taken_cnt, (k > 3) ? 3 : k);
      end
      if (resp_taken !== 1'b1) begin
        n_bad++; $display("FAIL nzp111_t got %b want 1", resp_taken);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    ld_cc = 1; cc_ctx = 3; cc_data = 16'h0042;
    tick();
    ld_cc = 0;
    br_valid = 1; br_ctx = 3; br_nzp = 3'b001; resp_ready = 0;
    tick();
    br_valid = 0; rst = 1;
    tick();
    rst = 0; resp_ready = 1;
    n_cmp += 2;
    if (resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_valid got %b want 0", resp_valid);
    end
    if (taken_cnt !== 2'd0) begin
      n_bad++; $display("FAIL rstmid_cnt got %0d want 0", taken_cnt);
    end
    br_valid = 1; br_nzp = 3'b010;
    for (int c = 0; c < 4; c++) begin
      br_ctx = 2'(c);
      tick();
      n_cmp++;
      if (resp_taken !== 1'b1) begin
        n_bad++; $display("FAIL rstmid_cc%0d got %b want 1", c, resp_taken);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      ld_cc      = $urandom_range(0, 1);
      cc_ctx     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cc_data = 16'h0000;
        1:       cc_data = 16'h8000 | 16'($urandom);
        2:       cc_data = (16'($urandom) & 16'h7fff) | 16'h0001;
        default: cc_data = 16'($urandom);
      endcase
      br_valid   = ($urandom_range(0, 3) != 0);
      br_ctx     = ($urandom_range(0, 2) == 0) ? cc_ctx : 2'($urandom_range(0, 3));
      br_nzp     = 3'($urandom_range(0, 7));
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++;
      if (br_ready !== (!m_valid || resp_ready)) begin
        n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, br_ready, !m_valid || resp_ready);
      end
      tick();
      n_cmp += 2;
      if (resp_valid !== m_valid) begin
        n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, resp_valid, m_valid);
      end
      if (taken_cnt !== 2'(m_cnt)) begin
        n_bad++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, taken_cnt, m_cnt);
      end
      if (m_valid) begin
        n_cmp += 2;
        if (resp_taken !== m_taken) begin
          n_bad++; $display("FAIL rnd_taken cyc %0d got %b want %b", i, resp_taken, m_taken);
        end
        if (resp_ctx !== 2'(m_ctx)) begin
          n_bad++; $display("FAIL rnd_ctx cyc %0d got %0d want %0d", i, resp_ctx, m_ctx);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    foreach (m_cc[i]) m_cc[i] = 0;
    m_valid = 0; m_taken = 0; m_ctx = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_contexts();
    test_forward();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
